bin2bcd_seq: RTL



---
 rtl/bin2bcd_seq.sv | 127 ++++++++++++
 1 files changed

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary to BCD converter, one bit per clock.
// Optional: define BIN2BCD_AUTO_CONV_EN to start on any change of numero.
module bin2bcd_seq #(
  parameter int BIN_W   = 27,
  parameter int DIGITS  = 8,
  parameter int MAX_VAL = 99999999
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BIN_W-1:0] numero,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [3:0]       num0,
  output logic [3:0]       num1,
  output logic [3:0]       num2,
  output logic [3:0]       num3,
  output logic [3:0]       num4,
  output logic [3:0]       num5,
  output logic [3:0]       num6,
  output logic [3:0]       num7
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_W + 1);
  localparam logic [BIN_W-1:0] MAX_B = BIN_W'(MAX_VAL);
  localparam logic [CW-1:0] CNT_LD = CW'(BIN_W);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t              state_q;
  logic [BIN_W-1:0]    bin_q;
  logic [BW-1:0]       bcd_q;
  logic [CW-1:0]       cnt_q;
  logic                of_q;
  logic [BW-1:0]       dig_q;
  logic                ovf_q;
  logic                done_q;
  logic [BW-1:0]       adj_d;
  logic [BW+BIN_W-1:0] sh_d;
  logic                trig;
  logic                take;

`ifdef BIN2BCD_AUTO_CONV_EN
  logic [BIN_W-1:0]    last_q;
  assign trig = start | (numero != last_q);
`else
  assign trig = start;
`endif

  // The DONE exit edge doubles as an accept edge for back-to-back runs.
  assign take = trig & ((state_q == IDLE) | (state_q == DONE));

  // Add-3 correction on every nibble, then shift the joint register.
  always_comb begin
    adj_d = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5)
        adj_d[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    sh_d = {adj_d, bin_q} << 1;
  end

  // Conversion FSM with registered digits, ovf and done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      of_q    <= 1'b0;
      dig_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
`ifdef BIN2BCD_AUTO_CONV_EN
      last_q  <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      if (take) begin
        state_q <= SHIFT;
        bcd_q   <= '0;
        cnt_q   <= CNT_LD;
        of_q    <= (numero > MAX_B);
        bin_q   <= (numero > MAX_B) ? '0 : numero;
`ifdef BIN2BCD_AUTO_CONV_EN
        last_q  <= numero;
`endif
      end else begin
        case (state_q)
          SHIFT: begin
            if (cnt_q != '0) begin
              bcd_q <= sh_d[BW+BIN_W-1:BIN_W];
              bin_q <= sh_d[BIN_W-1:0];
              cnt_q <= cnt_q - 1'b1;
            end else begin
              dig_q   <= bcd_q;
              ovf_q   <= of_q;
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end
          DONE:    state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign ovf  = ovf_q;
  assign num0 = dig_q[3:0];
  assign num1 = dig_q[7:4];
  assign num2 = dig_q[11:8];
  assign num3 = dig_q[15:12];
  assign num4 = dig_q[19:16];
  assign num5 = dig_q[23:20];
  assign num6 = dig_q[27:24];
  assign num7 = dig_q[31:28];

endmodule
